// File: rtl/ofdm_interleaver.sv
// 802.16 OFDM two-stage bit interleaver with ping-pong banks; OFDM_INTERLEAVER_DEINT_EN adds a gather-side deinterleave mode.
// Latency: out_valid rises the cycle after the last input beat of a block when the read side is idle.
// Backpressure: in_ready drops only while both banks hold blocks; out_blk/out_last hold while out_valid && !out_ready.
module ofdm_interleaver #(
  parameter int IN_W      = 1,
  parameter int MAX_NCBPS = 1152
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      rate_id,
  input  logic [2:0]      subchan_ct,
  input  logic [IN_W-1:0] in_blk,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [IN_W-1:0] out_blk,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            cfg_err
`ifdef OFDM_INTERLEAVER_DEINT_EN
  ,
  input  logic            deint
`endif
);

  localparam int AW = $clog2(MAX_NCBPS);
  localparam int NW = (AW < 11) ? 11 : AW;
  localparam logic [3:0] LAST_COL = 4'(12 - IN_W);
  localparam logic [3:0] COL_STEP = 4'(IN_W);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;

  // Rows per block (Ncbps/12): base/12 scaled by the subchannel count.
  function automatic logic [6:0] d_of(input logic [1:0] rid, input logic [2:0] sc);
    logic [6:0] unit;
    case (rid)
      2'd0:    unit = 7'd1;
      2'd1:    unit = 7'd2;
      2'd2:    unit = 7'd4;
      default: unit = 7'd6;
    endcase
    return unit << (3'd4 - sc);
  endfunction

  function automatic logic [1:0] s_of(input logic [1:0] rid);
    case (rid)
      2'd2:    return 2'd2;
      2'd3:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] mod3(input logic [3:0] c);
    case (c)
      4'd0, 4'd3, 4'd6, 4'd9:  return 2'd0;
      4'd1, 4'd4, 4'd7, 4'd10: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  // Rows per block are a multiple of s, so m mod s equals row mod s and the
  // second permutation reduces to swapping the residue for (row - col) mod s.
  function automatic logic [NW-1:0] perm_addr(input logic [3:0] c, input logic [6:0] r,
                                              input logic [1:0] r3, input logic [1:0] rid,
                                              input logic [2:0] sc);
    logic [NW-1:0] m;
    logic [1:0]    s;
    logic [1:0]    rm;
    logic [1:0]    cm;
    logic [2:0]    t;
    s  = s_of(rid);
    m  = NW'(c) * NW'(d_of(rid, sc)) + NW'(r);
    rm = 2'd0;
    cm = 2'd0;
    if (s == 2'd3) begin
      rm = r3;
      cm = mod3(c);
    end else if (s == 2'd2) begin
      rm = {1'b0, r[0]};
      cm = {1'b0, c[0]};
    end
    t = {1'b0, rm} + {1'b0, s} - {1'b0, cm};
    if (t >= {1'b0, s}) t = t - {1'b0, s};
    if (t >= {1'b0, s}) t = t - {1'b0, s};
    return m - NW'(rm) + NW'(t);
  endfunction

  function automatic logic [NW-1:0] seq_addr(input logic [3:0] c, input logic [6:0] r);
    return NW'(r) * NW'(12) + NW'(c);
  endfunction

  bank_st_t             bank_st  [2];
  bank_st_t             bank_nx  [2];
  logic [1:0]           bank_rid [2];
  logic [2:0]           bank_sc  [2];
  logic                 bank_dm  [2];
  logic [MAX_NCBPS-1:0] mem      [2];

  logic          wr_sel, rd_sel;
  logic [3:0]    wr_col, rd_col;
  logic [6:0]    wr_row, rd_row;
  logic [1:0]    wr_r3,  rd_r3;
  logic [NW-1:0] wr_addr [IN_W];
  logic [NW-1:0] rd_addr [IN_W];

  logic       live_dm;
  logic [2:0] live_sc;
  logic       wr_first, wr_fire, wr_last, wr_dm;
  logic [1:0] wr_rid;
  logic [2:0] wr_sc;
  logic [6:0] wr_d, rd_d;
  logic       rd_fire, rd_last, rd_dm;
  logic [1:0] rd_rid;
  logic [2:0] rd_sc;

`ifdef OFDM_INTERLEAVER_DEINT_EN
  assign live_dm = deint;
`else
  assign live_dm = 1'b0;
`endif

  assign live_sc = (subchan_ct > 3'd4) ? 3'd4 : subchan_ct;

  // The first beat of a block uses the live configuration; later beats use the latched copy.
  assign wr_first = (bank_st[wr_sel] == B_EMPTY);
  assign wr_rid   = wr_first ? rate_id : bank_rid[wr_sel];
  assign wr_sc    = wr_first ? live_sc : bank_sc[wr_sel];
  assign wr_dm    = wr_first ? live_dm : bank_dm[wr_sel];
  assign wr_d     = d_of(wr_rid, wr_sc);

  assign in_ready = (bank_st[wr_sel] == B_EMPTY) || (bank_st[wr_sel] == B_FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = (wr_row == wr_d - 7'd1) && (wr_col == LAST_COL);
  assign cfg_err  = wr_fire && wr_first && (subchan_ct > 3'd4);

  assign rd_rid    = bank_rid[rd_sel];
  assign rd_sc     = bank_sc[rd_sel];
  assign rd_dm     = bank_dm[rd_sel];
  assign rd_d      = d_of(rd_rid, rd_sc);
  assign out_valid = (bank_st[rd_sel] == B_FULL) || (bank_st[rd_sel] == B_DRAINING);
  assign rd_fire   = out_valid && out_ready;
  assign rd_last   = (rd_row == rd_d - 7'd1) && (rd_col == LAST_COL);
  assign out_last  = out_valid && rd_last;

  // Beats start on a multiple of IN_W, which divides 12, so col + i never wraps a row.
  always_comb begin
    for (int i = 0; i < IN_W; i++) begin
      wr_addr[i] = wr_dm ? seq_addr(wr_col + 4'(i), wr_row)
                         : perm_addr(wr_col + 4'(i), wr_row, wr_r3, wr_rid, wr_sc);
      rd_addr[i] = rd_dm ? perm_addr(rd_col + 4'(i), rd_row, rd_r3, rd_rid, rd_sc)
                         : seq_addr(rd_col + 4'(i), rd_row);
    end
  end

  always_comb begin
    out_blk = '0;
    if (out_valid) begin
      for (int i = 0; i < IN_W; i++) begin
        out_blk[i] = mem[rd_sel][rd_addr[i][AW-1:0]];
      end
    end
  end

  always_comb begin
    bank_nx[0] = bank_st[0];
    bank_nx[1] = bank_st[1];
    if (wr_fire) bank_nx[wr_sel] = wr_last ? B_FULL : B_FILLING;
    if (rd_fire) bank_nx[rd_sel] = rd_last ? B_EMPTY : B_DRAINING;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
    end else begin
      bank_st[0] <= bank_nx[0];
      bank_st[1] <= bank_nx[1];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < IN_W; i++) begin
        mem[wr_sel][wr_addr[i][AW-1:0]] <= in_blk[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel      <= 1'b0;
      wr_col      <= 4'd0;
      wr_row      <= 7'd0;
      wr_r3       <= 2'd0;
      bank_rid[0] <= 2'd0;
      bank_rid[1] <= 2'd0;
      bank_sc[0]  <= 3'd0;
      bank_sc[1]  <= 3'd0;
      bank_dm[0]  <= 1'b0;
      bank_dm[1]  <= 1'b0;
    end else if (wr_fire) begin
      if (wr_first) begin
        bank_rid[wr_sel] <= rate_id;
        bank_sc[wr_sel]  <= live_sc;
        bank_dm[wr_sel]  <= live_dm;
      end
      if (wr_last) begin
        wr_col <= 4'd0;
        wr_row <= 7'd0;
        wr_r3  <= 2'd0;
        wr_sel <= ~wr_sel;
      end else if (wr_col == LAST_COL) begin
        wr_col <= 4'd0;
        wr_row <= wr_row + 7'd1;
        wr_r3  <= (wr_r3 == 2'd2) ? 2'd0 : wr_r3 + 2'd1;
      end else begin
        wr_col <= wr_col + COL_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sel <= 1'b0;
      rd_col <= 4'd0;
      rd_row <= 7'd0;
      rd_r3  <= 2'd0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_col <= 4'd0;
        rd_row <= 7'd0;
        rd_r3  <= 2'd0;
        rd_sel <= ~rd_sel;
      end else if (rd_col == LAST_COL) begin
        rd_col <= 4'd0;
        rd_row <= rd_row + 7'd1;
        rd_r3  <= (rd_r3 == 2'd2) ? 2'd0 : rd_r3 + 2'd1;
      end else begin
        rd_col <= rd_col + COL_STEP;
      end
    end
  end

endmodule

// File: doc/ofdm_interleaver.md
# ofdm_interleaver

Parametrised two-stage 802.16 OFDM bit interleaver covering all four modulations (BPSK, QPSK, 16-QAM, 64-QAM) and all five subchannel counts (1, 2, 4, 8, 16).
- Sits between the convolutional encoder and the constellation mapper.
- Accepts a stream of IN_W-bit beats and emits the same block permuted per the standard's first and second permutations.
- Uses a ping-pong buffer, so consecutive blocks stream at full rate.

## Interface
- IN_W, 1: bits per beat, in and out; legal values 1, 2, 3, 4, 6, 12 (must divide every Ncbps).
- MAX_NCBPS, 1152: bank depth in bits; must be ≥ the largest Ncbps used.
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rate_id  in  2  modulation: 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM.
- subchan_ct  in  3  subchannel code: 0 → 16, 1 → 8, 2 → 4, 3 → 2, 4 → 1.
- in_blk  in  IN_W  input beat; bit 0 is the earliest coded bit.
- in_valid / in_ready  in / out  1  input handshake.
- out_blk  out  IN_W  output beat.
- out_valid / out_ready  out / in  1  output handshake.
- out_last  out  1  marks the final beat of a block.
- cfg_err  out  1  one-cycle pulse when an illegal subchan_ct is latched.

## Operation
- Ncbps = base × (16 >> subchan_ct); base is 12, 24, 48, 72 for rate_id 0..3.
- s = 1, 1, 2, 3 for rate_id 0..3.
- rate_id and subchan_ct are latched on the first accepted beat of each block; they are ignored for the rest of the block.
- subchan_ct 5–7 is treated as 4 and pulses cfg_err in the latch cycle.
- Input bit index k runs 0..Ncbps−1 and is tracked as col = k mod 12, row = k / 12; there are no dividers.
  - m = col·(Ncbps/12) + row.
  - j = s·⌊m/s⌋ + ((m + Ncbps − col) mod s).
  - col replaces ⌊12m/Ncbps⌋.
- Interleave mode: input bit k is written to bank address j (scatter); output is read sequentially, address IN_W·beat + i.
- Two banks, A and B, each holding MAX_NCBPS bits plus a stored Ncbps.
- The write side fills one bank; when the last bit is written the bank goes FULL and write switches to the other bank.
- The read side drains a FULL bank in Ncbps/IN_W beats, then frees it.
- Per-bank state machine: EMPTY → FILLING (first beat accepted) → FULL (last beat accepted) → DRAINING (first out beat taken) → EMPTY (last out beat taken).
- in_ready = 0 only when the target write bank is FULL or DRAINING, i.e. both banks are occupied.
- out_valid = 1 while the read bank is FULL or DRAINING.
- Data is held stable while out_valid && !out_ready.
- Simultaneous final write into one bank and final read from the other in the same cycle are both legal; there is no stall.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_blk = 0, out_last = 0, cfg_err = 0.
- On reset both banks go EMPTY and the bit counters clear.
- Reset asserted mid-block discards all partial and full blocks.
- Latency: out_valid rises the cycle after the last input beat of a block is accepted, when the read side is idle.
- Sustained throughput is one beat per cycle in each direction.
- out_last is high with the beat where the beat index = Ncbps/IN_W − 1.
- Configuration changes between blocks take effect on the next block only.

## Configuration
- OFDM_INTERLEAVER_DEINT_EN defined:
  - Adds input port `deint` (1 bit), latched with rate_id.
  - deint = 1: input is written sequentially; output beat bit (IN_W·beat + i) reads bank address j of that index (gather), giving the exact inverse permutation.
  - deint = 0: interleave.
- Undefined: no `deint` port; interleave only.

## Test plan
- QPSK, subchan_ct 0 (Ncbps 384), IN_W = 1, single 1 at k = 1 -> output bit 32 high, all others 0; out_last on beat 383; out_valid rises the cycle after input beat 383.
- 64-QAM, subchan_ct 0 (Ncbps 1152), IN_W = 1, single 1 at k = 13 -> output bit 96 high.
- 16-QAM, subchan_ct 4 (Ncbps 48), IN_W = 4, single 1 at k = 1 -> output bit 5 high (beat 1, bit 1); 12 output beats.
- Back-to-back BPSK/16 (192 bits) then QPSK/1 (24 bits) with out_ready = 1 -> in_ready stays 1, both blocks correct in order, no bubble.
- out_ready held 0 for 3 blocks -> in_ready drops after the second block completes; no data loss after release; subchan_ct = 6 -> cfg_err one-cycle pulse, Ncbps uses code 4.
- Reset pulse mid-block and mid-drain -> all outputs return to reset values immediately; a following block interleaves correctly; with the macro, deint(interleave(x)) = x for all 20 configurations.
